dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data SRAM (11-bit word address, async read port, sync write) between two requesters: port 0 = CPU data port, port 1 = program loader / debug DMA.
- Issues at most one memory command per cycle, registered toward the SRAM.
- Uses round-robin arbitration with optional locked bursts and a bounded burst length so neither port starves.
- Sits between flow_cpu / loader and the data memory inside top.

Parameters:
- ADDR_W, 11, word-address width (byte address bits 12:2).
- DATA_W, 32, data width.
- MAX_BURST, 8, maximum consecutive grants to one locked port while the other is requesting (>=1).
- CNT_W, 4, burst counter width; must hold MAX_BURST.

Ports:
- clk_in  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request, held until gnt0.
- we0  in  1  port 0 write (1) / read (0).
- lock0  in  1  port 0 requests to keep the grant on following cycles.
- addr0  in  ADDR_W  port 0 word address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  port 0 request accepted this cycle (combinational).
- rvalid0  out  1  port 0 read data valid.
- req1, we1, lock1, addr1, wdata1, gnt1, rvalid1: same as port 0, for port 1.
- rdata  out  DATA_W  shared read return; equals mem_rdata.
- mem_addr  out  ADDR_W  SRAM address (registered).
- mem_we  out  1  SRAM write enable (registered).
- mem_wdata  out  DATA_W  SRAM write data (registered).
- mem_rdata  in  DATA_W  SRAM async read data (dpo).

Behaviour:
- States: IDLE, OWN0, OWN1 (OWNx = port x granted last cycle). Also a round-robin pointer last (0/1) and a burst counter bcnt.
- Reset (async, any cycle including mid-burst):
  - state=IDLE, last=1 (port 0 wins first tie), bcnt=0.
  - mem_addr=0, mem_we=0, mem_wdata=0.
  - rvalid0=rvalid1=0; gnt0=gnt1=0 while reset high.
  - An in-flight read is dropped; no rvalid is issued after reset.
- Grant selection (combinational, cycle N):
  - Only one requester: that port is granted.
  - Both requesting, state OWNx, lockx=1 and bcnt<MAX_BURST-1: port x is granted again.
  - Otherwise, both requesting: grant the port != last.
  - Neither requesting: no grant; state goes to IDLE; bcnt cleared.
  - Never both gnt high.
- Edge ending cycle N with a grant to port x:
  - mem_addr<=addrx, mem_wdata<=wdatax, mem_we<=wex, last<=x, state<=OWNx.
  - bcnt<=bcnt+1 if x equals the previous owner, else 0.
  - bcnt saturates at MAX_BURST-1.
- With no grant: mem_we<=0; mem_addr and mem_wdata hold their values.
- Write latency: the SRAM write occurs at the edge ending cycle N+1.
- Read latency: rvalidx=1 during cycle N+1 only if the grant was a read; rdata=mem_rdata for mem_addr in that cycle.
- rvalid pulses for one cycle per granted read; back-to-back reads give rvalid every cycle.
- Lock only extends ownership when the other port is requesting; lock with no competitor has no effect.
- When the burst limit is hit, the grant passes to the other port for at least one cycle; the locked port may then win again via round-robin.
- Locked burst cap check: after MAX_BURST consecutive grants with the other port waiting, the next grant must go to the other port.
- No combinational path from mem_rdata to any gnt.
- Request fields are sampled only in the grant cycle; requesters may change them after gnt.

Test Plan:
- Reset, then req0=1, we0=0, addr0=0x010, with SRAM[0x010]=0xDEADBEEF -> gnt0 in cycle 0; mem_addr=0x010 and rvalid0=1, rdata=0xDEADBEEF in cycle 1; rvalid1 stays 0.
- req0 and req1 both held high, no lock, for 6 cycles -> grants alternate 0,1,0,1,0,1, starting with port 0.
- req1 writes (addr1=0x005, wdata1=0x12345678), then the following cycle req0 reads 0x005 -> rvalid0 with rdata=0x12345678 two cycles after the write grant.
- lock0=1 and req0, req1 both held continuously, MAX_BURST=8 -> 8 consecutive gnt0, then 1 gnt1, then port 0 again; no cycle has both gnts high.
- reset asserted asynchronously mid-burst, one cycle after a read grant -> mem_we=0, rvalid0=0 immediately; after release, a tie is granted to port 0.
- Neither port requesting for 3 cycles -> mem_we=0, no rvalid, mem_addr holds its last value, state IDLE.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the data SRAM, with lockable bursts
// capped at MAX_BURST grants while the other port is waiting.
module dmem_arbiter #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 4
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [CNT_W-1:0] BCAP = CNT_W'(MAX_BURST - 1);

  state_t            r_state, w_state_nxt;
  logic              r_last;
  logic [CNT_W-1:0]  r_bcnt, w_bcnt_nxt;
  logic              w_gnt0, w_gnt1, w_burst_ok, w_same;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we, r_rvalid0, r_rvalid1;

  assign w_burst_ok = (r_bcnt < BCAP);

  // State register
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  // Next-state: ownership follows the grant; any idle cycle ends the burst
  always_comb begin
    w_state_nxt = IDLE;
    if (w_gnt0)      w_state_nxt = OWN0;
    else if (w_gnt1) w_state_nxt = OWN1;
    w_same = (w_gnt0 && r_state == OWN0) || (w_gnt1 && r_state == OWN1);
    w_bcnt_nxt = '0;
    if (w_same) w_bcnt_nxt = (r_bcnt >= BCAP) ? BCAP : r_bcnt + 1'b1;
  end

  // Grant outputs; lock only matters when both ports compete
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && !req1)      w_gnt0 = 1'b1;
      else if (req1 && !req0) w_gnt1 = 1'b1;
      else if (req0 && req1) begin
        if (r_state == OWN0 && lock0 && w_burst_ok)      w_gnt0 = 1'b1;
        else if (r_state == OWN1 && lock1 && w_burst_ok) w_gnt1 = 1'b1;
        else if (r_last)                                 w_gnt0 = 1'b1;
        else                                             w_gnt1 = 1'b1;
      end
    end
  end

  // Registered SRAM command and read-valid tracking
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_last      <= 1'b1;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0 && !we0;
      r_rvalid1 <= w_gnt1 && !we1;
      if (w_gnt0) begin
        r_mem_addr  <= addr0;
        r_mem_wdata <= wdata0;
        r_mem_we    <= we0;
        r_last      <= 1'b0;
      end else if (w_gnt1) begin
        r_mem_addr  <= addr1;
        r_mem_wdata <= wdata1;
        r_mem_we    <= we1;
        r_last      <= 1'b1;
      end else begin
        r_mem_we    <= 1'b0;
      end
    end
  end

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign rdata     = mem_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed stimulus pushes expected grants
// and read returns; a negedge monitor pops and compares them.
module tb_dmem_arbiter;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        req0, we0, lock0, req1, we1, lock1;
  logic [10:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [10:0] mem_addr;
  logic        mem_we;

  typedef struct {
    bit          port;
    logic [31:0] data;
  } rd_t;

  bit  gq[$];
  rd_t rdq[$];

  int n_run = 0, n_fail = 0;
  int mon_run = 0, mon_fail = 0;

  always #5 clk_in = ~clk_in;

  dmem_arbiter dut (
    .clk_in(clk_in), .reset(reset),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // SRAM model: async read, write on the clock edge
  logic [31:0] sram [0:2047];
  bit loaded = 1'b0;
  assign mem_rdata = sram[mem_addr];
  always @(posedge clk_in) begin
    if (!loaded) begin
      sram[11'h010] <= 32'hDEADBEEF;
      sram[11'h020] <= 32'hCAFEF00D;
      sram[11'h005] <= 32'h00000000;
      loaded        <= 1'b1;
    end else if (mem_we) begin
      sram[mem_addr] <= mem_wdata;
    end
  end

  // Monitor
  initial begin
    bit  eg;
    rd_t er;
    forever begin
      @(negedge clk_in);
      if (gnt0 && gnt1) begin
        mon_run++; mon_fail++;
        $display("FAIL both_gnt: gnt0=1 gnt1=1, want at most one");
      end else if (gnt0 || gnt1) begin
        mon_run++;
        if (gq.size() == 0) begin
          mon_fail++;
          $display("FAIL unexp_gnt: got grant to port %0d, want none", gnt1);
        end else begin
          eg = gq.pop_front();
          if (gnt1 !== eg) begin
            mon_fail++;
            $display("FAIL gnt_port @%0t: got port %0d, want port %0d", $time, gnt1, eg);
          end
        end
      end
      if (rvalid0 && rvalid1) begin
        mon_run++; mon_fail++;
        $display("FAIL both_rvalid: rvalid0=1 rvalid1=1");
      end else if (rvalid0 || rvalid1) begin
        mon_run++;
        if (rdq.size() == 0) begin
          mon_fail++;
          $display("FAIL unexp_rvalid: got rvalid port %0d data %h, want none", rvalid1, rdata);
        end else begin
          er = rdq.pop_front();
          if (rvalid1 !== er.port || rdata !== er.data) begin
            mon_fail++;
            $display("FAIL rvalid @%0t: got port %0d data %h, want port %0d data %h",
                     $time, rvalid1, rdata, er.port, er.data);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_rd(input bit p, input logic [31:0] d);
    rd_t r;
    r.port = p;
    r.data = d;
    rdq.push_back(r);
  endtask

  task automatic drop();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
  endtask

  initial begin
    reset = 1; drop();
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(posedge clk_in);
    #1 req0 = 1; req1 = 1;
    @(negedge clk_in);
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(rvalid1), 32'd0);
    step(); reset = 0; drop();

    // Single read by port 0
    step(); req0 = 1; addr0 = 11'h010;
    gq.push_back(1'b0); push_rd(1'b0, 32'hDEADBEEF);
    step(); drop();
    @(negedge clk_in);
    chk("s1_mem_addr", 32'(mem_addr), 32'h010);
    chk("s1_rvalid0", 32'(rvalid0), 32'd1);
    chk("s1_rvalid1", 32'(rvalid1), 32'd0);

    // Fresh reset, then alternating ties
    step(); reset = 1;
    step(); reset = 0;
    req0 = 1; req1 = 1; addr0 = 11'h010; addr1 = 11'h020;
    for (int i = 0; i < 6; i++) begin
      gq.push_back(i[0]);
      push_rd(i[0], i[0] ? 32'hCAFEF00D : 32'hDEADBEEF);
    end
    repeat (6) @(posedge clk_in);
    #1 drop();

    // Port 1 write then port 0 read-back
    req1 = 1; we1 = 1; addr1 = 11'h005; wdata1 = 32'h12345678;
    gq.push_back(1'b1);
    step(); drop(); req0 = 1; addr0 = 11'h005;
    gq.push_back(1'b0); push_rd(1'b0, 32'h12345678);
    @(negedge clk_in);
    chk("s3_mem_we", 32'(mem_we), 32'd1);
    chk("s3_mem_addr", 32'(mem_addr), 32'h005);
    chk("s3_mem_wdata", mem_wdata, 32'h12345678);
    step(); drop();

    // Locked burst from port 0 against a waiting port 1
    step(); req0 = 1; lock0 = 1; addr0 = 11'h010; addr1 = 11'h020;
    for (int i = 0; i < 8; i++) begin
      gq.push_back(1'b0); push_rd(1'b0, 32'hDEADBEEF);
    end
    gq.push_back(1'b1); push_rd(1'b1, 32'hCAFEF00D);
    gq.push_back(1'b0); push_rd(1'b0, 32'hDEADBEEF);
    step(); req1 = 1;
    repeat (9) @(posedge clk_in);
    #1 drop();

    // Async reset one cycle after a read grant
    step(); req0 = 1; addr0 = 11'h010;
    gq.push_back(1'b0);
    step();
    #1 reset = 1;
    #1;
    chk("s5_rvalid0", 32'(rvalid0), 32'd0);
    chk("s5_mem_we", 32'(mem_we), 32'd0);
    chk("s5_gnt0", 32'(gnt0), 32'd0);
    req1 = 1;
    step(); reset = 0;
    gq.push_back(1'b0); push_rd(1'b0, 32'hDEADBEEF);
    step(); drop();

    // Idle: command and address hold, then a tie shows ownership was lost
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk("s6_mem_we", 32'(mem_we), 32'd0);
      chk("s6_mem_addr", 32'(mem_addr), 32'h010);
      chk("s6_rvalid0", 32'(rvalid0), 32'd0);
      chk("s6_rvalid1", 32'(rvalid1), 32'd0);
      step();
    end
    req0 = 1; req1 = 1; lock0 = 1;
    gq.push_back(1'b1); push_rd(1'b1, 32'hCAFEF00D);
    step(); drop();

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    #1;
    chk("gq_empty", 32'(gq.size()), 32'd0);
    chk("rdq_empty", 32'(rdq.size()), 32'd0);
    n_run  += mon_run;
    n_fail += mon_fail;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
